// File: rtl/bht_pht_if.sv
// Fetch-lookup and resolve-update signals shared between the pipeline and the
// gshare branch history table.
interface bht_pht_if #(
    parameter int INDEX_BITS = 4
);
    logic [15:0]           fetch_pc;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  load_bht;
    logic                  clear_bht;
    logic [INDEX_BITS-1:0] update_index;
    logic                  update_taken;
    logic                  bht_ready;

    modport master (
        output fetch_pc, load_bht, clear_bht, update_index, update_taken,
        input  pred_taken, pred_index, bht_ready
    );

    modport slave (
        input  fetch_pc, load_bht, clear_bht, update_index, update_taken,
        output pred_taken, pred_index, bht_ready
    );
endinterface

// File: rtl/bht_pht.sv
// gshare predictor: 2-bit saturating counters indexed by PC^GHR, with an
// init sweep after reset that writes every entry to weakly not-taken.
module bht_pht #(
    parameter int INDEX_BITS = 4,
    parameter int HIST_BITS  = 4   // 1..INDEX_BITS
) (
    input logic      clk,
    input logic      rst,
    bht_pht_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic                  ready;
    logic [INDEX_BITS-1:0] init_cnt;
    logic [HIST_BITS-1:0]  ghr;
    logic [HIST_BITS-1:0]  ghr_next;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            tbl [ENTRIES];
    logic [1:0]            cur;
    logic                  unused_pc;

    assign unused_pc = ^{bus.fetch_pc[15:INDEX_BITS+1], bus.fetch_pc[0]};

    always_comb begin
        ghr_ext                = '0;
        ghr_ext[HIST_BITS-1:0] = ghr;
    end

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_next = bus.update_taken;
        end else begin : g_histn
            assign ghr_next = {ghr[HIST_BITS-2:0], bus.update_taken};
        end
    endgenerate

    // Lookup reads the pre-update entry; writes land at the edge, no bypass.
    assign idx            = bus.fetch_pc[INDEX_BITS:1] ^ ghr_ext;
    assign bus.pred_index = idx;
    assign bus.pred_taken = ready & tbl[idx][1];
    assign bus.bht_ready  = ready;
    assign cur            = tbl[bus.update_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            ready    <= 1'b0;
            init_cnt <= '0;
            ghr      <= '0;
        end else begin
            case (state)
                INIT: begin
                    tbl[init_cnt] <= 2'b01;
                    init_cnt      <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // Clear re-seeds the entry toward the resolved direction and wins over training.
                    if (bus.clear_bht)
                        tbl[bus.update_index] <= bus.update_taken ? 2'b10 : 2'b01;
                    else if (bus.load_bht) begin
                        if (bus.update_taken && cur != 2'b11)
                            tbl[bus.update_index] <= cur + 2'b01;
                        else if (!bus.update_taken && cur != 2'b00)
                            tbl[bus.update_index] <= cur - 2'b01;
                    end
                    if (bus.load_bht)
                        ghr <= ghr_next;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bht_pht.sv
// Self-checking bench for bht_pht: vector table plus hand sequences, with
// expected outputs queued at drive time and popped when outputs are sampled.
module tb_bht_pht;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bht_pht_if #(.INDEX_BITS(4)) bus();
    bht_pht #(.INDEX_BITS(4), .HIST_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] pc;
        logic        load;
        logic        clr;
        logic [3:0]  ui;
        logic        ut;
        logic        exp_taken;
        logic [3:0]  exp_idx;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        int         tag;
        logic       taken;
        logic [3:0] idx;
        logic       ready;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tag   = 0;

    task automatic chk(input string name, input int t, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h want %h", name, t, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.fetch_pc     = '0;
        bus.load_bht     = 1'b0;
        bus.clear_bht    = 1'b0;
        bus.update_index = '0;
        bus.update_taken = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus, check the combinational outputs, then take the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        bus.fetch_pc     = v.pc;
        bus.load_bht     = v.load;
        bus.clear_bht    = v.clr;
        bus.update_index = v.ui;
        bus.update_taken = v.ut;
        sb.push_back('{tag, v.exp_taken, v.exp_idx, v.exp_ready});
        tag++;
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            chk("pred_taken", e.tag, {3'b0, bus.pred_taken}, {3'b0, e.taken});
            chk("pred_index", e.tag, bus.pred_index, e.idx);
            chk("bht_ready",  e.tag, {3'b0, bus.bht_ready}, {3'b0, e.ready});
        end
        @(posedge clk); #1;
    endtask

    vec_t       gv [12];
    logic       sat_t [8];
    logic       sat_e [8];
    logic [3:0] ghr_m;
    logic [3:0] i4;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gv[0]  = '{16'h0000, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1};
        gv[1]  = '{16'h0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1};
        gv[2]  = '{16'h0000, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 4'h2, 1'b1};
        gv[3]  = '{16'h0000, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 4'h5, 1'b1};
        gv[4]  = '{16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b1};
        gv[5]  = '{16'h001E, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h4, 1'b1};
        gv[6]  = '{16'h0018, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 1'b1};
        gv[7]  = '{16'h0018, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 4'h7, 1'b1};
        gv[8]  = '{16'h0004, 1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 1'b1};
        gv[9]  = '{16'h0004, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 1'b1};
        gv[10] = '{16'h000A, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 4'h2, 1'b1};
        gv[11] = '{16'h001A, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 1'b1};
        sat_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sat_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        set_idle();
        @(posedge clk); #1;
        do_reset();

        // Init sweep: ready low for exactly 16 cycles, then every entry weakly not-taken.
        for (int i = 0; i < 16; i++) begin
            i4 = 4'(i);
            apply('{{11'b0, i4, 1'b0}, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, i4, 1'b0});
        end
        for (int i = 0; i < 16; i++) begin
            i4 = 4'(i);
            apply('{{11'b0, i4, 1'b0}, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, i4, 1'b1});
        end

        // Mid-sweep reset with training traffic that must be ignored during INIT.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            i4 = 4'(i);
            apply('{{11'b0, i4, 1'b0}, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, i4, 1'b0});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i4 = 4'(i);
            apply('{{11'b0, i4, 1'b0}, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, i4, 1'b0});
        end
        for (int i = 0; i < 16; i++) begin
            i4 = 4'(i);
            apply('{{11'b0, i4, 1'b0}, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, i4, 1'b1});
        end

        // GHR/index, clear priority and same-cycle read/write vectors.
        do_reset();
        repeat (16) @(posedge clk);
        #1;
        foreach (gv[k]) apply(gv[k]);

        // Saturation on entry 3; fetch PC tracks the GHR so the lookup stays on index 3.
        do_reset();
        repeat (16) @(posedge clk);
        #1;
        ghr_m = 4'h0;
        for (int k = 0; k < 8; k++) begin
            i4 = 4'h3 ^ ghr_m;
            apply('{{11'b0, i4, 1'b0}, 1'b1, 1'b0, 4'h3, sat_t[k], sat_e[k], 4'h3, 1'b1});
            ghr_m = {ghr_m[2:0], sat_t[k]};
        end
        i4 = 4'h3 ^ ghr_m;
        apply('{{11'b0, i4, 1'b0}, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
